// File: rtl/ddr3_pkg.sv
// Shared DDR3 definitions for the read and write paths.
//   CMD_READ / CMD_WRITE : MIG app_cmd encodings
//   state_e              : reader FSM state encoding
package ddr3_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst      : clock, synchronous active-high reset (clears pointers)
//   wr_en, wdata  : push a word (dropped if full and no pop this cycle)
//   rd_en         : pop the head word (ignored when empty)
//   rdata         : current head word, valid whenever empty is low
//   empty         : no words stored
//   count         : number of words stored, 0 .. 2**ASIZE
module sync_fifo #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rd_en,
    output logic [DSIZE-1:0] rdata,
    output logic             empty,
    output logic [ASIZE:0]   count
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [ASIZE:0]   wptr_q, wptr_d;
    logic [ASIZE:0]   rptr_q, rptr_d;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count = wptr_q - rptr_q;
    assign empty = (count == '0);
    assign full  = (count == (ASIZE+1)'(DEPTH));

    // At full, a simultaneous pop frees the slot the push lands in.
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    assign rdata = mem_q[rptr_q[ASIZE-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_wr) wptr_d = wptr_q + 1'b1;
        if (do_rd) rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q[ASIZE-1:0]] <= wdata;
    end

endmodule

// File: rtl/ddr3_reader.sv
// Streams a block of DDR3 back out through the MIG app interface.
// On start, one read command is issued per app address from min to max
// inclusive; the low DW bits of each returned beat are queued in order and
// offered to the consumer.
//   ui_clk, rst                 : MIG user clock, synchronous active-high reset
//   start                       : 1-cycle pulse, latches min/max when idle
//   app_addr_rd_min/_max        : inclusive app address range
//   busy, done                  : transfer in progress / 1-cycle completion pulse
//   app_rdy, app_en, app_cmd,
//   app_addr                    : MIG command channel
//   app_rd_data(_valid)         : MIG read data return (cannot be stalled)
//   rd_data, rd_valid, rd_ready : output stream
//   state_dbg                   : current FSM state (ddr3_pkg::state_e encoding)
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the rising edge. valid never waits for ready, and once valid is
// raised it and its payload stay unchanged until that transfer.
module ddr3_reader
    import ddr3_pkg::*;
#(
    parameter int ADDR_W     = 33,
    parameter int APP_DW     = 128,
    parameter int DW         = 16,
    parameter int FIFO_ASIZE = 4
) (
    input  logic              ui_clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] app_addr_rd_min,
    input  logic [ADDR_W-1:0] app_addr_rd_max,
    output logic              busy,
    output logic              done,
    input  logic              app_rdy,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    input  logic [APP_DW-1:0] app_rd_data,
    input  logic              app_rd_data_valid,
    output logic [DW-1:0]     rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [1:0]        state_dbg
);

    localparam int DEPTH = 1 << FIFO_ASIZE;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [ADDR_W-1:0]     max_q, max_d;
    logic [FIFO_ASIZE:0]   outst_q, outst_d;
    logic                  done_q, done_d;

    logic [FIFO_ASIZE:0]   fifo_count;
    logic                  fifo_empty;
    logic [FIFO_ASIZE+1:0] credit_sum;
    logic                  credit_ok;
    logic                  accept;
    logic                  beat;
    logic                  done_now;
    logic                  unused_hi;

    // Only the low lane carries payload; the writer masks the rest.
    assign unused_hi = ^app_rd_data[APP_DW-1:DW];

    // Every issued-but-unreturned read owns a FIFO slot, so returning data
    // always fits. Without an accept this sum never grows, which keeps
    // app_en stable while the MIG stalls.
    assign credit_sum = {1'b0, outst_q} + {1'b0, fifo_count};
    assign credit_ok  = (credit_sum < (FIFO_ASIZE+2)'(DEPTH));

    assign accept = app_en & app_rdy;
    // Beats arriving while idle belong to a transfer killed by reset.
    assign beat   = app_rd_data_valid & (state_q != IDLE);

    sync_fifo #(
        .DSIZE (DW),
        .ASIZE (FIFO_ASIZE)
    ) u_fifo (
        .clk   (ui_clk),
        .rst   (rst),
        .wr_en (beat),
        .wdata (app_rd_data[DW-1:0]),
        .rd_en (rd_valid & rd_ready),
        .rdata (rd_data),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rd_valid  = ~fifo_empty;
    assign app_cmd   = CMD_READ;
    assign app_addr  = addr_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q | done_now;
    assign state_dbg = state_q;

    always_comb begin
        outst_d = outst_q;
        if (accept && !beat) begin
            outst_d = outst_q + 1'b1;
        end else if (beat && !accept && outst_q != '0) begin
            outst_d = outst_q - 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        max_d    = max_q;
        done_d   = 1'b0;
        done_now = 1'b0;
        app_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d = app_addr_rd_min;
                    max_d  = app_addr_rd_max;
                    // An empty range completes without touching the MIG.
                    if (app_addr_rd_min > app_addr_rd_max) done_d  = 1'b1;
                    else                                   state_d = ISSUE;
                end
            end
            ISSUE: begin
                app_en = credit_ok;
                if (accept) begin
                    // Compare before increment so max = all-ones cannot wrap.
                    if (addr_q == max_q) state_d = DRAIN;
                    else                 addr_d  = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (outst_q == '0 && fifo_empty) begin
                    done_now = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ui_clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            max_q   <= '0;
            outst_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            max_q   <= max_d;
            outst_q <= outst_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_ddr3_reader.sv
module tb_ddr3_reader;

    localparam int ADDR_W = 33;
    localparam int APP_DW = 128;
    localparam int DW     = 16;

    logic              ui_clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] app_addr_rd_min = '0;
    logic [ADDR_W-1:0] app_addr_rd_max = '0;
    logic              busy, done;
    logic              app_rdy = 1'b1;
    logic              app_en;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic [APP_DW-1:0] app_rd_data = '0;
    logic              app_rd_data_valid = 1'b0;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic              rd_ready = 1'b1;
    logic [1:0]        state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- clock ----------------
    always #5 ui_clk = ~ui_clk;

    ddr3_reader dut (
        .ui_clk            (ui_clk),
        .rst               (rst),
        .start             (start),
        .app_addr_rd_min   (app_addr_rd_min),
        .app_addr_rd_max   (app_addr_rd_max),
        .busy              (busy),
        .done              (done),
        .app_rdy           (app_rdy),
        .app_en            (app_en),
        .app_cmd           (app_cmd),
        .app_addr          (app_addr),
        .app_rd_data       (app_rd_data),
        .app_rd_data_valid (app_rd_data_valid),
        .rd_data           (rd_data),
        .rd_valid          (rd_valid),
        .rd_ready          (rd_ready),
        .state_dbg         (state_dbg)
    );

    // Payload the MIG model stores at each address.
    function automatic logic [DW-1:0] exp_word(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ 16'hC3A5 ^ {a[7:0], 8'h00};
    endfunction

    // ---------------- MIG model + logs ----------------
    int                rdy_mode = 0;  // 0: app_rdy=1, 1: random
    int                rd_mode  = 1;  // 0: rd_ready=0, 1: rd_ready=1, 2: random
    int                cyc = 0;
    logic [ADDR_W-1:0] pend_addr_q[$];
    int                pend_due_q[$];
    logic [ADDR_W-1:0] cmd_q[$];
    logic [DW-1:0]     got_q[$];
    int                done_cnt  = 0;
    int                stall_err = 0;
    int                hold_err  = 0;
    bit                prev_stall = 1'b0;
    bit                prev_hold  = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DW-1:0]     prev_rd   = '0;

    // Runs 1ns after each falling edge, after the test tasks have driven.
    // Drives app_rdy / rd_ready / read data for the coming rising edge.
    always begin
        @(negedge ui_clk);
        #1;
        cyc++;
        if (!rst && prev_stall && (app_en !== 1'b1 || app_addr !== prev_addr)) stall_err++;
        if (!rst && prev_hold && (rd_valid !== 1'b1 || rd_data !== prev_rd)) hold_err++;
        app_rdy  = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        rd_ready = (rd_mode == 0) ? 1'b0 : (rd_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        // The MIG accepts whenever en & rdy, regardless of our reset.
        if (app_en === 1'b1 && app_rdy) begin
            pend_addr_q.push_back(app_addr);
            pend_due_q.push_back(cyc + 3);
            if (!rst) cmd_q.push_back(app_addr);
        end
        if (!rst && rd_valid === 1'b1 && rd_ready) got_q.push_back(rd_data);
        if (!rst && done === 1'b1) done_cnt++;
        prev_stall = !rst && app_en === 1'b1 && !app_rdy;
        prev_addr  = app_addr;
        prev_hold  = !rst && rd_valid === 1'b1 && !rd_ready;
        prev_rd    = rd_data;
        app_rd_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (pend_due_q.size() > 0 && pend_due_q[0] <= cyc) begin
            app_rd_data[DW-1:0] = exp_word(pend_addr_q[0]);
            app_rd_data_valid   = 1'b1;
            void'(pend_addr_q.pop_front());
            void'(pend_due_q.pop_front());
        end else begin
            app_rd_data_valid = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_logs();
        cmd_q.delete();
        got_q.delete();
        done_cnt = 0;
    endtask

    task automatic start_xfer(input logic [ADDR_W-1:0] mn, input logic [ADDR_W-1:0] mx);
        @(negedge ui_clk);
        start = 1'b1;
        app_addr_rd_min = mn;
        app_addr_rd_max = mx;
        @(negedge ui_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int c0;
        c0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge ui_clk);
            #2;
            if (done_cnt > c0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge ui_clk);
        n_cmp++; if (app_en !== 1'b0) begin n_fail++; $display("FAIL reset_app_en got=%b exp=0", app_en); end
        n_cmp++; if (app_addr !== 33'h0) begin n_fail++; $display("FAIL reset_app_addr got=%h exp=0", app_addr); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        n_cmp++; if (app_cmd !== 3'b001) begin n_fail++; $display("FAIL reset_app_cmd got=%b exp=001", app_cmd); end
        n_cmp++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        rdy_mode = 0; rd_mode = 1;
        clear_logs();
        start_xfer(33'h10, 33'h13);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got=%b exp=1", busy); end
        n_cmp++; if (app_en !== 1'b1 || app_addr !== 33'h10) begin n_fail++; $display("FAIL basic_first_cmd en=%b addr=%h exp en=1 addr=10", app_en, app_addr); end
        wait_done(100, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_done_timeout got=no_done exp=done"); end
        n_cmp++; if (cmd_q.size() != 4) begin n_fail++; $display("FAIL basic_cmd_count got=%0d exp=4", cmd_q.size()); end
        n_cmp++; if (got_q.size() != 4) begin n_fail++; $display("FAIL basic_word_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < 4 && i < cmd_q.size(); i++) begin
            n_cmp++; if (cmd_q[i] !== 33'h10 + 33'(i)) begin n_fail++; $display("FAIL basic_cmd[%0d] got=%h exp=%h", i, cmd_q[i], 33'h10 + 33'(i)); end
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_word(33'h10 + 33'(i))) begin n_fail++; $display("FAIL basic_word[%0d] got=%h exp=%h", i, got_q[i], exp_word(33'h10 + 33'(i))); end
        end
        @(negedge ui_clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_after done=%b busy=%b exp 0 0", done, busy); end
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_single();
        bit ok;
        clear_logs();
        start_xfer(33'h5, 33'h5);
        wait_done(100, ok);
        repeat (3) @(negedge ui_clk);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_done_timeout got=no_done exp=done"); end
        n_cmp++; if (cmd_q.size() != 1 || cmd_q[0] !== 33'h5) begin n_fail++; $display("FAIL single_cmd count=%0d exp 1 cmd at 5", cmd_q.size()); end
        n_cmp++; if (got_q.size() != 1 || got_q[0] !== 16'hC6A0) begin n_fail++; $display("FAIL single_word count=%0d exp 1 word c6a0", got_q.size()); end
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL single_done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_empty_range();
        clear_logs();
        start_xfer(33'h8, 33'h7);
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL empty_done got=%b exp=1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy got=%b exp=0", busy); end
        @(negedge ui_clk);
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL empty_done_pulse got=%b exp=0", done); end
        repeat (6) @(negedge ui_clk);
        n_cmp++; if (cmd_q.size() != 0) begin n_fail++; $display("FAIL empty_cmds got=%0d exp=0", cmd_q.size()); end
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL empty_done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2;
        clear_logs();
        start_xfer(33'h20, 33'h22);
        repeat (2) @(negedge ui_clk);
        start_xfer(33'h80, 33'h90);  // busy: must be ignored
        wait_done(100, ok1);
        start_xfer(33'h23, 33'h25);
        wait_done(100, ok2);
        repeat (2) @(negedge ui_clk);
        n_cmp++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL b2b_done_timeout got=%b%b exp=11", ok1, ok2); end
        n_cmp++; if (cmd_q.size() != 6) begin n_fail++; $display("FAIL b2b_cmd_count got=%0d exp=6", cmd_q.size()); end
        for (int i = 0; i < 6 && i < cmd_q.size(); i++) begin
            n_cmp++; if (cmd_q[i] !== 33'h20 + 33'(i)) begin n_fail++; $display("FAIL b2b_cmd[%0d] got=%h exp=%h", i, cmd_q[i], 33'h20 + 33'(i)); end
        end
        n_cmp++; if (got_q.size() != 6) begin n_fail++; $display("FAIL b2b_word_count got=%0d exp=6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_word(33'h20 + 33'(i))) begin n_fail++; $display("FAIL b2b_word[%0d] got=%h exp=%h", i, got_q[i], exp_word(33'h20 + 33'(i))); end
        end
        n_cmp++; if (done_cnt != 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad_cmd, bad_word;
        rdy_mode = 0; rd_mode = 0;
        hold_err = 0;
        clear_logs();
        start_xfer(33'h100, 33'h13F);
        repeat (60) @(negedge ui_clk);
        n_cmp++; if (cmd_q.size() != 16) begin n_fail++; $display("FAIL bp_credit_cmds got=%0d exp=16", cmd_q.size()); end
        n_cmp++; if (app_en !== 1'b0) begin n_fail++; $display("FAIL bp_app_en got=%b exp=0", app_en); end
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 16'hC2A5) begin n_fail++; $display("FAIL bp_head valid=%b data=%h exp 1 c2a5", rd_valid, rd_data); end
        rd_mode = 1;
        wait_done(500, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_done_timeout got=no_done exp=done"); end
        n_cmp++; if (cmd_q.size() != 64 || got_q.size() != 64) begin n_fail++; $display("FAIL bp_counts cmds=%0d words=%0d exp 64 64", cmd_q.size(), got_q.size()); end
        bad_cmd = 0; bad_word = 0;
        for (int i = 0; i < 64 && i < cmd_q.size(); i++)
            if (cmd_q[i] !== 33'h100 + 33'(i)) bad_cmd++;
        for (int i = 0; i < 64 && i < got_q.size(); i++)
            if (got_q[i] !== exp_word(33'h100 + 33'(i))) bad_word++;
        n_cmp++; if (bad_cmd != 0) begin n_fail++; $display("FAIL bp_cmd_order bad=%0d exp=0", bad_cmd); end
        n_cmp++; if (bad_word != 0) begin n_fail++; $display("FAIL bp_word_order bad=%0d exp=0", bad_word); end
        n_cmp++; if (hold_err != 0) begin n_fail++; $display("FAIL bp_rd_hold violations=%0d exp=0", hold_err); end
    endtask

    task automatic test_random_rdy();
        bit ok;
        int bad_cmd, bad_word;
        rdy_mode = 1; rd_mode = 2;
        stall_err = 0; hold_err = 0;
        clear_logs();
        start_xfer(33'h1F0, 33'h21F);
        wait_done(2000, ok);
        rdy_mode = 0; rd_mode = 1;
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rand_done_timeout got=no_done exp=done"); end
        n_cmp++; if (cmd_q.size() != 48 || got_q.size() != 48) begin n_fail++; $display("FAIL rand_counts cmds=%0d words=%0d exp 48 48", cmd_q.size(), got_q.size()); end
        bad_cmd = 0; bad_word = 0;
        for (int i = 0; i < 48 && i < cmd_q.size(); i++)
            if (cmd_q[i] !== 33'h1F0 + 33'(i)) bad_cmd++;
        for (int i = 0; i < 48 && i < got_q.size(); i++)
            if (got_q[i] !== exp_word(33'h1F0 + 33'(i))) bad_word++;
        n_cmp++; if (bad_cmd != 0) begin n_fail++; $display("FAIL rand_cmd_order bad=%0d exp=0", bad_cmd); end
        n_cmp++; if (bad_word != 0) begin n_fail++; $display("FAIL rand_word_order bad=%0d exp=0", bad_word); end
        n_cmp++; if (stall_err != 0) begin n_fail++; $display("FAIL rand_cmd_stable violations=%0d exp=0", stall_err); end
        n_cmp++; if (hold_err != 0) begin n_fail++; $display("FAIL rand_rd_hold violations=%0d exp=0", hold_err); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        rdy_mode = 0; rd_mode = 1;
        clear_logs();
        start_xfer(33'h300, 33'h31F);
        repeat (3) @(negedge ui_clk);  // three reads accepted, none returned yet
        n_cmp++; if (cmd_q.size() != 3) begin n_fail++; $display("FAIL rmid_outstanding got=%0d exp=3", cmd_q.size()); end
        rst = 1'b1;
        @(negedge ui_clk);
        n_cmp++; if (app_en !== 1'b0 || app_addr !== 33'h0) begin n_fail++; $display("FAIL rmid_cmd en=%b addr=%h exp 0 0", app_en, app_addr); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_outs busy=%b done=%b valid=%b exp 0 0 0", busy, done, rd_valid); end
        rst = 1'b0;
        clear_logs();
        repeat (8) @(negedge ui_clk);
        n_cmp++; if (got_q.size() != 0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale words=%0d valid=%b exp 0 0", got_q.size(), rd_valid); end
        n_cmp++; if (done_cnt != 0) begin n_fail++; $display("FAIL rmid_no_done got=%0d exp=0", done_cnt); end
        start_xfer(33'h40, 33'h43);
        wait_done(100, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rmid_restart_timeout got=no_done exp=done"); end
        n_cmp++; if (got_q.size() != 4) begin n_fail++; $display("FAIL rmid_restart_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_word(33'h40 + 33'(i))) begin n_fail++; $display("FAIL rmid_word[%0d] got=%h exp=%h", i, got_q[i], exp_word(33'h40 + 33'(i))); end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_single();
        test_empty_range();
        test_back_to_back();
        test_backpressure();
        test_random_rdy();
        test_reset_mid();
        repeat (2) @(negedge ui_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
